// File: rtl/uart0_tx_regs_if.sv
// Load/store bus between the address decoder / memory stage and UART0.
// The master drives the access strobes; the slave (UART0) returns load data.
interface uart0_tx_regs_if #(
  parameter int XLEN = 32
);
  logic            uart_addr_detect;
  logic [XLEN-1:0] uart_addr;
  logic            mem_wr_en;
  logic            mem_rd_en;
  logic [XLEN-1:0] mem_wr_data;
  logic [XLEN-1:0] uart_rd_data;

  modport master (
    output uart_addr_detect, uart_addr, mem_wr_en, mem_rd_en, mem_wr_data,
    input  uart_rd_data
  );

  modport slave (
    input  uart_addr_detect, uart_addr, mem_wr_en, mem_rd_en, mem_wr_data,
    output uart_rd_data
  );
endinterface

// File: rtl/uart0_tx_regs.sv
// UART0 transmitter with memory-mapped registers.
// TXDATA pushes bytes into a small FIFO; a 4-state FSM pops them and sends
// 8N1 frames, LSB first, with a bit period of BAUD_DIV+1 clocks. The divider
// is captured at frame start so reprogramming only affects later frames.
module uart0_tx_regs #(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 8,
  parameter int BAUD_DIV_RST = 434
) (
  input  logic               clk,
  input  logic               rst,
  uart0_tx_regs_if.slave     bus,
  output logic               uart_tx,
  output logic               uart_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state_q, state_d;
  logic [15:0]     baud_cnt_q, baud_cnt_d;
  logic [15:0]     div_lat_q, div_lat_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            uart_tx_q, uart_tx_d;
  logic            irq_q, irq_d;

  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     baud_div_q, baud_div_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;

  logic            pop;
  logic            push;
  logic            wr_txdata;
  logic            fifo_full;
  logic            fifo_empty;
  logic            busy;
  logic [3:0]      count_field;
  logic [1:0]      word_sel;
  logic            unused_bits;

  assign word_sel    = bus.uart_addr[3:2];
  assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty  = (count_q == '0);
  assign busy        = (state_q != S_IDLE);
  assign count_field = 4'(count_q);
  assign wr_txdata   = bus.uart_addr_detect & bus.mem_wr_en & (word_sel == 2'd0);
  // A write into a full FIFO still lands if the FSM frees a slot this cycle.
  assign push        = wr_txdata & (~fifo_full | pop);
  assign unused_bits = ^{bus.uart_addr[XLEN-1:4], bus.uart_addr[1:0],
                         bus.mem_wr_data[XLEN-1:16]};

  // Transmit FSM: frame sequencing, baud timing and the output shifter.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    div_lat_d  = div_lat_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = fifo_mem[rd_ptr_q];
          div_lat_d  = baud_div_q;
          baud_cnt_d = baud_div_q;
          state_d    = S_START;
        end
      end
      default: begin
        if (baud_cnt_q != 16'd0) begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end else begin
          baud_cnt_d = div_lat_q;
          case (state_q)
            S_START: begin
              state_d   = S_DATA;
              bit_idx_d = 3'd0;
            end
            S_DATA: begin
              shift_d = {1'b0, shift_q[7:1]};
              if (bit_idx_q == 3'd7) state_d = S_STOP;
              else bit_idx_d = bit_idx_q + 3'd1;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase
    case (state_d)
      S_START: uart_tx_d = 1'b0;
      S_DATA:  uart_tx_d = shift_d[0];
      default: uart_tx_d = 1'b1;
    endcase
  end

  // Register file, FIFO bookkeeping and registered load data.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    baud_div_d = baud_div_q;
    rd_data_d  = rd_data_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
    if (wr_txdata && fifo_full && !pop) ovf_d = 1'b1;
    if (bus.uart_addr_detect && bus.mem_wr_en) begin
      if (word_sel == 2'd1 && bus.mem_wr_data[3]) ovf_d = 1'b0;
      if (word_sel == 2'd2) baud_div_d = bus.mem_wr_data[15:0];
    end
    if (bus.mem_rd_en) begin
      rd_data_d = '0;
      if (bus.uart_addr_detect) begin
        case (word_sel)
          2'd1:    rd_data_d = XLEN'({count_field, ovf_q, fifo_empty, fifo_full, busy});
          2'd2:    rd_data_d = XLEN'(baud_div_q);
          default: rd_data_d = '0;
        endcase
      end
    end
    irq_d = (count_d == '0) & (state_d == S_IDLE);
  end

  // FIFO storage; contents need no reset because the pointers are flushed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.mem_wr_data[7:0];
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      div_lat_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      uart_tx_q  <= 1'b1;
      irq_q      <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      baud_div_q <= 16'(BAUD_DIV_RST);
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      div_lat_q  <= div_lat_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      uart_tx_q  <= uart_tx_d;
      irq_q      <= irq_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      baud_div_q <= baud_div_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign uart_tx          = uart_tx_q;
  assign uart_irq         = irq_q;
  assign bus.uart_rd_data = rd_data_q;
endmodule
